// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared widths, tap geometry helpers and sequencer state type
//
// Purpose : common definitions for the 2x2 output-stationary convolution core.
// Contents: DATA_W  pixel/tap/result width
//           ACC_W   per-PE accumulator width (9 * 255 * 255 fits in 20 bits)
//           NTAPS   number of filter taps (3x3)
//           TAP_W   width of a tap index / sequencer counter
//           NPIX    number of image pixels (4x4)
//           state_t sequencer states
//           tap_row / tap_col map a tap index k = 3*kr + kc back to (kr, kc)
package systolic_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int NTAPS  = 9;
  localparam int TAP_W  = 4;
  localparam int NPIX   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Filter row of tap k (k = 3*kr + kc). Indices past the last tap map to 0;
  // they are never accumulated because their valid bit is low.
  function automatic logic [1:0] tap_row(input logic [TAP_W-1:0] k);
    logic [1:0] r;
    case (k)
      4'd0, 4'd1, 4'd2: r = 2'd0;
      4'd3, 4'd4, 4'd5: r = 2'd1;
      4'd6, 4'd7, 4'd8: r = 2'd2;
      default:          r = 2'd0;
    endcase
    return r;
  endfunction

  // Filter column of tap k.
  function automatic logic [1:0] tap_col(input logic [TAP_W-1:0] k);
    logic [1:0] c;
    case (k)
      4'd0, 4'd3, 4'd6: c = 2'd0;
      4'd1, 4'd4, 4'd7: c = 2'd1;
      4'd2, 4'd5, 4'd8: c = 2'd2;
      default:          c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - one multiply-accumulate processing element of the 2x2 array
//
// Purpose : accumulates i[ROW+kr][COL+kc] * f[kr][kc] for every tap that
//           arrives on its tap inputs, forwards the tap one register stage
//           downstream, and captures the low byte of its sum on load.
// Params  : ROW, COL   output position of this PE (0 or 1 each)
// Ports   : clk        rising-edge clock
//           rst        asynchronous active-high reset
//           img        all 16 pixels, img[4*row + col]
//           tap_valid  a tap is present this cycle
//           tap_idx    tap index k = 3*kr + kc
//           tap_weight filter tap f[kr][kc]
//           load       capture acc[7:0] into result
//           fwd_valid  registered copy of tap_valid for the next PE
//           fwd_idx    registered copy of tap_idx
//           fwd_weight registered copy of tap_weight
//           result     registered 8-bit result (acc modulo 256)
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int ROW = 0,
  parameter int COL = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NPIX-1:0][DATA_W-1:0]  img,
  input  logic                         tap_valid,
  input  logic [TAP_W-1:0]             tap_idx,
  input  logic [DATA_W-1:0]            tap_weight,
  input  logic                         load,
  output logic                         fwd_valid,
  output logic [TAP_W-1:0]             fwd_idx,
  output logic [DATA_W-1:0]            fwd_weight,
  output logic [DATA_W-1:0]            result
);

  logic [1:0]          pix_row;
  logic [1:0]          pix_col;
  logic [DATA_W-1:0]   pixel;
  logic [2*DATA_W-1:0] product;
  logic [ACC_W-1:0]    acc;

  // The PE's own offset plus the filter offset names the pixel under the tap.
  // ROW/COL are at most 1 and kr/kc at most 2, so the sums fit in 2 bits.
  assign pix_row = 2'(ROW) + tap_row(tap_idx);
  assign pix_col = 2'(COL) + tap_col(tap_idx);
  assign pixel   = img[{pix_row, pix_col}];

  assign product = {{DATA_W{1'b0}}, pixel} * {{DATA_W{1'b0}}, tap_weight};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (tap_valid) begin
      acc <= acc + {{(ACC_W - 2*DATA_W){1'b0}}, product};
    end
  end

  // One register stage per hop gives the diagonal wavefront downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_valid  <= 1'b0;
      fwd_idx    <= '0;
      fwd_weight <= '0;
    end else begin
      fwd_valid  <= tap_valid;
      fwd_idx    <= tap_idx;
      fwd_weight <= tap_weight;
    end
  end

  // Result is held until the next reset; only the single load pulse writes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (load) begin
      result <= acc[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/two_by_two_systolic_array.sv
// rtl/two_by_two_systolic_array.sv - 2x2 output-stationary systolic 3x3 convolution core
//
// Purpose : 3x3 valid-mode cross-correlation of a 4x4 8-bit image with a
//           3x3 8-bit filter, producing a 2x2 8-bit map (modulo 256).
//           A tap sequencer feeds PE00; taps ripple PE00 -> PE01/PE10 ->
//           PE11, and all four results are captured together on edge 11.
// Ports   : clk          rising-edge clock
//           rst          asynchronous active-high reset
//           i00..i33     image pixels i[row][col]
//           f00..f22     filter taps f[row][col]
//           o00..o11     results o[r][c], zero until captured, then held
module two_by_two_systolic_array
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i00,
  input  logic [DATA_W-1:0] i01,
  input  logic [DATA_W-1:0] i02,
  input  logic [DATA_W-1:0] i03,
  input  logic [DATA_W-1:0] i10,
  input  logic [DATA_W-1:0] i11,
  input  logic [DATA_W-1:0] i12,
  input  logic [DATA_W-1:0] i13,
  input  logic [DATA_W-1:0] i20,
  input  logic [DATA_W-1:0] i21,
  input  logic [DATA_W-1:0] i22,
  input  logic [DATA_W-1:0] i23,
  input  logic [DATA_W-1:0] i30,
  input  logic [DATA_W-1:0] i31,
  input  logic [DATA_W-1:0] i32,
  input  logic [DATA_W-1:0] i33,
  input  logic [DATA_W-1:0] f00,
  input  logic [DATA_W-1:0] f01,
  input  logic [DATA_W-1:0] f02,
  input  logic [DATA_W-1:0] f10,
  input  logic [DATA_W-1:0] f11,
  input  logic [DATA_W-1:0] f12,
  input  logic [DATA_W-1:0] f20,
  input  logic [DATA_W-1:0] f21,
  input  logic [DATA_W-1:0] f22,
  output logic [DATA_W-1:0] o00,
  output logic [DATA_W-1:0] o01,
  output logic [DATA_W-1:0] o10,
  output logic [DATA_W-1:0] o11
);

  // Counter value on which the results are captured: taps occupy 0..8,
  // PE11 finishes its last tap on edge 10, so the capture edge is 11.
  localparam logic [TAP_W-1:0] LOAD_CNT = TAP_W'(NTAPS + 2);
  localparam logic [TAP_W-1:0] TAP_END  = TAP_W'(NTAPS);

  logic [NPIX-1:0][DATA_W-1:0]  img;
  logic [NTAPS-1:0][DATA_W-1:0] filt;

  state_t            state;
  logic [TAP_W-1:0]  cnt;
  logic              tap_valid;
  logic [DATA_W-1:0] tap_weight;
  logic              load;

  logic              v00, v01, v10, v11;
  logic [TAP_W-1:0]  k00, k01, k10, k11;
  logic [DATA_W-1:0] w00, w01, w10, w11;
  logic              unused_fwd;

  assign img  = {i33, i32, i31, i30, i23, i22, i21, i20,
                 i13, i12, i11, i10, i03, i02, i01, i00};
  assign filt = {f22, f21, f20, f12, f11, f10, f02, f01, f00};

  // ------------------------------------------------------------------
  // Tap sequencer. IDLE is the reset state; the first edge after reset
  // already consumes tap 0, so IDLE hands over to RUN with the counter
  // advanced to 1. RUN walks taps 0..8, drains two cycles, then captures.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
          cnt   <= cnt + 1'b1;
        end
        RUN: begin
          if (cnt == LOAD_CNT) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign tap_valid = (state != DONE) && (cnt < TAP_END);
  assign load      = (state == RUN) && (cnt == LOAD_CNT);

  always_comb begin
    tap_weight = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (cnt == TAP_W'(k)) begin
        tap_weight = filt[k];
      end
    end
  end

  // ------------------------------------------------------------------
  // PE grid. PE01 and PE10 both listen to PE00; PE11 takes the copy that
  // came through PE01 (PE10 carries the identical tap on the same cycle).
  // ------------------------------------------------------------------
  systolic_pe #(.ROW(0), .COL(0)) u_pe00 (
    .clk        (clk),
    .rst        (rst),
    .img        (img),
    .tap_valid  (tap_valid),
    .tap_idx    (cnt),
    .tap_weight (tap_weight),
    .load       (load),
    .fwd_valid  (v00),
    .fwd_idx    (k00),
    .fwd_weight (w00),
    .result     (o00)
  );

  systolic_pe #(.ROW(0), .COL(1)) u_pe01 (
    .clk        (clk),
    .rst        (rst),
    .img        (img),
    .tap_valid  (v00),
    .tap_idx    (k00),
    .tap_weight (w00),
    .load       (load),
    .fwd_valid  (v01),
    .fwd_idx    (k01),
    .fwd_weight (w01),
    .result     (o01)
  );

  systolic_pe #(.ROW(1), .COL(0)) u_pe10 (
    .clk        (clk),
    .rst        (rst),
    .img        (img),
    .tap_valid  (v00),
    .tap_idx    (k00),
    .tap_weight (w00),
    .load       (load),
    .fwd_valid  (v10),
    .fwd_idx    (k10),
    .fwd_weight (w10),
    .result     (o10)
  );

  systolic_pe #(.ROW(1), .COL(1)) u_pe11 (
    .clk        (clk),
    .rst        (rst),
    .img        (img),
    .tap_valid  (v01),
    .tap_idx    (k01),
    .tap_weight (w01),
    .load       (load),
    .fwd_valid  (v11),
    .fwd_idx    (k11),
    .fwd_weight (w11),
    .result     (o11)
  );

  // Edge-of-array forward copies have no consumer.
  assign unused_fwd = ^{v10, k10, w10, v11, k11, w11};

endmodule

// File: tb/tb_two_by_two_systolic_array.sv
// tb/tb_two_by_two_systolic_array.sv - scoreboard bench for the 2x2 systolic convolution core
module tb_two_by_two_systolic_array;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] img [16];
  logic [7:0] filt [9];
  logic [7:0] o00, o01, o10, o11;

  int          errors = 0;
  int          checks = 0;
  int          ecount = 0;
  logic [31:0] exp_q [$];
  logic [31:0] held = '0;
  bit          have_exp = 1'b0;

  always #5 clk = ~clk;

  two_by_two_systolic_array dut (
    .clk (clk), .rst (rst),
    .i00 (img[0]),  .i01 (img[1]),  .i02 (img[2]),  .i03 (img[3]),
    .i10 (img[4]),  .i11 (img[5]),  .i12 (img[6]),  .i13 (img[7]),
    .i20 (img[8]),  .i21 (img[9]),  .i22 (img[10]), .i23 (img[11]),
    .i30 (img[12]), .i31 (img[13]), .i32 (img[14]), .i33 (img[15]),
    .f00 (filt[0]), .f01 (filt[1]), .f02 (filt[2]),
    .f10 (filt[3]), .f11 (filt[4]), .f12 (filt[5]),
    .f20 (filt[6]), .f21 (filt[7]), .f22 (filt[8]),
    .o00 (o00), .o01 (o01), .o10 (o10), .o11 (o11)
  );

  // Edges seen since reset was released: after edge k this reads k+1.
  always @(posedge clk or posedge rst) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at t=%0t edges=%0d: got o00..o11=%h required %h", name, $time, ecount, got, want);
    end
  endtask

  // Reference: direct 3x3 cross-correlation, low byte of each sum.
  function automatic logic [31:0] model();
    logic [7:0] res [4];
    int s;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        s = 0;
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            s += int'(img[(r + kr) * 4 + c + kc]) * int'(filt[kr * 3 + kc]);
        res[r * 2 + c] = 8'(s % 256);
      end
    end
    return {res[0], res[1], res[2], res[3]};
  endfunction

  // Monitor: zero while in reset or before the capture edge, then the
  // expected map popped from the scoreboard, then the same map held.
  always @(negedge clk) begin
    logic [31:0] got;
    got = {o00, o01, o10, o11};
    if (rst) begin
      have_exp = 1'b0;
      check("reset_zero", got, 32'h0);
    end else if (ecount <= 11) begin
      check("pre_result_zero", got, 32'h0);
    end else begin
      if (!have_exp) begin
        have_exp = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL no_expectation at t=%0t: got %h required a queued result", $time, got);
          held = got;
        end else begin
          held = exp_q.pop_front();
        end
      end
      check(ecount == 12 ? "result_cycle12" : "result_held", got, held);
    end
  end

  task automatic set_nominal_image();
    img = '{8'd9, 8'd8, 8'd2, 8'd6, 8'd0, 8'd4, 8'd1, 8'd6,
            8'd4, 8'd10, 8'd1, 8'd1, 8'd2, 8'd2, 8'd9, 8'd9};
  endtask

  task automatic set_nominal_filter();
    filt = '{8'd3, 8'd2, 8'd0, 8'd2, 8'd0, 8'd1, 8'd3, 8'd1, 8'd1};
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 9; i++)  filt[i] = 8'($urandom_range(0, 255));
  endtask

  // Pulse reset with the current inputs applied and queue the expectation.
  task automatic start_run(input logic [31:0] want);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2;
    exp_q.push_back(want);
    rst = 1'b0;
  endtask

  initial begin
    set_nominal_image();
    set_nominal_filter();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal case.
    start_run(32'h434A223B);
    repeat (16) @(posedge clk);

    // Centre-impulse filter.
    filt = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    start_run(32'h04010A01);
    repeat (16) @(posedge clk);

    // Overflow wrap: 9 * 255 * 255 mod 256 = 9.
    for (int i = 0; i < 16; i++) img[i] = 8'hFF;
    for (int i = 0; i < 9; i++)  filt[i] = 8'hFF;
    start_run(32'h09090909);
    repeat (16) @(posedge clk);

    // All-zero filter with a random image.
    randomize_inputs();
    for (int i = 0; i < 9; i++) filt[i] = 8'h00;
    start_run(32'h0);
    repeat (16) @(posedge clk);

    // Mid-run reset at cycle 5; the queued expectation survives the restart.
    set_nominal_image();
    set_nominal_filter();
    start_run(32'h434A223B);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    repeat (16) @(posedge clk);

    // Post-DONE: new inputs are ignored until reset, then computed.
    randomize_inputs();
    repeat (6) @(posedge clk);
    start_run(model());
    repeat (16) @(posedge clk);

    // Random images and filters.
    for (int n = 0; n < 5; n++) begin
      randomize_inputs();
      start_run(model());
      repeat (15) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
